vec_ram_arb: RTL and testbench

Round-robin arbiter and sequencer that shares the single-port `vec_ram` (64-bit data, byte-strobed writes, registered read data) among `N_REQ` requesters, such as the host bus bridge and the vector load/store unit. It accepts one beat per cycle and supports locked multi-beat bursts. It returns each beat's read data to the requester that issued it, and rejects out-of-range addresses with an error response.

---
 rtl/vec_ram_arb.sv | 182 ++++++++++++++++++
 tb/tb_vec_ram_arb.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_ram_arb.sv
// vec_ram_arb: round-robin arbiter and sequencer for the single-port vec_ram.
// Requesters present one beat per cycle, multi-beat bursts lock the RAM to
// their owner, and each beat gets a one-cycle response carrying the RAM read
// data (or an error for addresses beyond the implemented RAM).
module vec_ram_arb #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 64,
  parameter int STRB_W = 8,
  parameter int RAM_AW = 15
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [N_REQ-1:0]           req_valid_i,
  output logic [N_REQ-1:0]           req_ready_o,
  input  logic [N_REQ-1:0]           req_last_i,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr_i,
  input  logic [N_REQ*STRB_W-1:0]    req_we_i,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata_i,
  output logic [N_REQ-1:0]           rsp_valid_o,
  output logic                       rsp_err_o,
  output logic [DATA_W-1:0]          rsp_rdata_o,
  output logic                       ram_en_o,
  output logic [STRB_W-1:0]          ram_we_o,
  output logic [ADDR_W-1:0]          ram_addr_o,
  output logic [DATA_W-1:0]          ram_d_o,
  input  logic [DATA_W-1:0]          ram_d_i
);

  localparam int IDW = $clog2(N_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  typedef logic [IDW-1:0] id_t;

  // Arbitration state
  state_e state_q, state_d;
  id_t    rr_q, rr_d;
  id_t    owner_q, owner_d;

  // Response pipeline
  logic   pend_q;
  id_t    pid_q;
  logic   perr_q;

  // Winner of the current cycle
  logic   win_found;
  id_t    win_id;
  id_t    cand;

  // Selected beat
  logic [ADDR_W-1:0] win_addr;
  logic [STRB_W-1:0] win_we;
  logic [DATA_W-1:0] win_wdata;
  logic              win_last;
  logic              accept;
  logic              out_of_range;

  // Unpacked per-requester views of the packed buses
  logic [ADDR_W-1:0] addr_a  [N_REQ];
  logic [STRB_W-1:0] we_a    [N_REQ];
  logic [DATA_W-1:0] wdata_a [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr_i[g*ADDR_W +: ADDR_W];
    assign we_a[g]    = req_we_i[g*STRB_W +: STRB_W];
    assign wdata_a[g] = req_wdata_i[g*DATA_W +: DATA_W];
  end

  // Pick the winner: the lock owner while locked, otherwise the first valid
  // requester at or above rr_q, wrapping modulo N_REQ. Nobody wins in reset.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    if (state_q == LOCK) begin
      win_id    = owner_q;
      win_found = req_valid_i[owner_q];
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        cand = (int'(rr_q) + i >= N_REQ) ? id_t'(int'(rr_q) + i - N_REQ)
                                         : id_t'(int'(rr_q) + i);
        if (!win_found && req_valid_i[cand]) begin
          win_found = 1'b1;
          win_id    = cand;
        end
      end
    end
    if (!rst_ni) begin
      win_found = 1'b0;
    end
  end

  assign accept       = win_found;
  assign win_addr     = addr_a[win_id];
  assign win_we       = we_a[win_id];
  assign win_wdata    = wdata_a[win_id];
  assign win_last     = req_last_i[win_id];
  assign out_of_range = |win_addr[ADDR_W-1:RAM_AW];

  // One-hot ready to the winning requester
  always_comb begin
    req_ready_o = '0;
    if (accept) begin
      req_ready_o[win_id] = 1'b1;
    end
  end

  // Present the accepted in-range beat to the RAM in its accept cycle
  always_comb begin
    ram_en_o   = 1'b0;
    ram_we_o   = '0;
    ram_addr_o = '0;
    ram_d_o    = '0;
    if (accept && !out_of_range) begin
      ram_en_o   = 1'b1;
      ram_we_o   = win_we;
      ram_addr_o = win_addr;
      ram_d_o    = win_wdata;
    end
  end

  // Burst lock and round-robin pointer update on each accepted beat
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    if (accept) begin
      if (win_last) begin
        state_d = IDLE;
        rr_d    = (win_id == id_t'(N_REQ - 1)) ? '0 : win_id + id_t'(1);
      end else if (state_q == IDLE) begin
        state_d = LOCK;
        owner_d = win_id;
      end
    end
  end

  // Arbitration state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
    end
  end

  // Record the accepted beat so its response lines up with the RAM read data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
      pid_q  <= '0;
      perr_q <= 1'b0;
    end else begin
      pend_q <= accept;
      pid_q  <= win_id;
      perr_q <= out_of_range;
    end
  end

  // Response pulse to the issuing requester; error beats return zero data
  always_comb begin
    rsp_valid_o = '0;
    rsp_err_o   = 1'b0;
    rsp_rdata_o = '0;
    if (pend_q) begin
      rsp_valid_o[pid_q] = 1'b1;
      rsp_err_o          = perr_q;
      rsp_rdata_o        = perr_q ? '0 : ram_d_i;
    end
  end

endmodule

// File: tb/tb_vec_ram_arb.sv
// tb_vec_ram_arb: directed bench for vec_ram_arb with a byte-addressed
// vec_ram model (registered read, big-endian byte lanes). Accepted beats
// push their expected response into a scoreboard; a monitor pops and compares.
module tb_vec_ram_arb;

  localparam int N      = 2;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 64;
  localparam int STRB_W = 8;
  localparam int RAM_AW = 15;
  localparam int MEM_BYTES = 1 << RAM_AW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Per-requester drive state
  logic [N-1:0]      valid;
  logic [N-1:0]      last;
  logic [ADDR_W-1:0] addr  [N];
  logic [STRB_W-1:0] we    [N];
  logic [DATA_W-1:0] wdata [N];
  logic [DATA_W-1:0] cur_rdata [N];
  logic              cur_err   [N];

  logic [N*ADDR_W-1:0] req_addr;
  logic [N*STRB_W-1:0] req_we;
  logic [N*DATA_W-1:0] req_wdata;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_addr[g*ADDR_W +: ADDR_W]  = addr[g];
    assign req_we[g*STRB_W +: STRB_W]    = we[g];
    assign req_wdata[g*DATA_W +: DATA_W] = wdata[g];
  end

  logic [N-1:0]      req_ready_o;
  logic [N-1:0]      rsp_valid_o;
  logic              rsp_err_o;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              ram_en_o;
  logic [STRB_W-1:0] ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_d_o;
  logic [DATA_W-1:0] ram_q;

  vec_ram_arb #(
    .N_REQ(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W), .RAM_AW(RAM_AW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (valid),
    .req_ready_o (req_ready_o),
    .req_last_i  (last),
    .req_addr_i  (req_addr),
    .req_we_i    (req_we),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid_o),
    .rsp_err_o   (rsp_err_o),
    .rsp_rdata_o (rsp_rdata_o),
    .ram_en_o    (ram_en_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_d_o     (ram_d_o),
    .ram_d_i     (ram_q)
  );

  // vec_ram model: byte at the lowest address sits in bits 63:56, strobe bit 7
  logic [7:0] mem [MEM_BYTES];
  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = i[7:0];
    ram_q = '0;
  end

  always @(posedge clk) begin
    if (ram_en_o) begin
      for (int b = 0; b < 8; b++) begin
        ram_q[63-8*b -: 8] <= mem[(int'(ram_addr_o[RAM_AW-1:0]) + b) % MEM_BYTES];
        if (ram_we_o[7-b])
          mem[(int'(ram_addr_o[RAM_AW-1:0]) + b) % MEM_BYTES] <= ram_d_o[63-8*b -: 8];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard
  typedef struct {
    int          id;
    logic        err;
    logic [63:0] rdata;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  exp_t e;

  // Record every accepted beat together with its expected response
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < N; k++) begin
        if (valid[k] && req_ready_o[k]) begin
          sb.push_back('{id: k, err: cur_err[k], rdata: cur_rdata[k], acc_cyc: cyc});
          grant_log.push_back(k);
        end
      end
    end
  end

  // Compare every response the DUT presents against the oldest expectation
  always @(negedge clk) begin
    if (rsp_valid_o != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_valid_o), 64'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_id",      64'(rsp_valid_o), 64'(1) << e.id);
        check("rsp_err",     64'(rsp_err_o), 64'(e.err));
        check("rsp_rdata",   rsp_rdata_o, e.rdata);
        check("rsp_latency", 64'(cyc - e.acc_cyc), 64'd1);
      end
    end
  end

  // Present one beat from requester k and wait (bounded) for its accept.
  // Returns at the accept-cycle falling edge with valid still held.
  task automatic send(input int k, input logic [ADDR_W-1:0] a, input logic [STRB_W-1:0] s,
                      input logic [DATA_W-1:0] d, input logic l,
                      input logic [DATA_W-1:0] exp_rd, input logic exp_err,
                      output int acc);
    @(posedge clk); #1;
    addr[k] = a; we[k] = s; wdata[k] = d; last[k] = l;
    cur_rdata[k] = exp_rd; cur_err[k] = exp_err;
    valid[k] = 1'b1;
    acc = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready_o[k]) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: requester %0d addr %h never accepted", k, a);
      valid[k] = 1'b0;
    end
  endtask

  task automatic idle(input int k);
    @(posedge clk); #1;
    valid[k] = 1'b0;
    last[k]  = 1'b0;
    we[k]    = '0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"},  64'(req_ready_o), 64'd0);
    check({tag, "_ram_en"}, 64'(ram_en_o), 64'd0);
    check({tag, "_rsp_v"},  64'(rsp_valid_o), 64'd0);
    check({tag, "_rsp_e"},  64'(rsp_err_o), 64'd0);
    check({tag, "_rsp_d"},  rsp_rdata_o, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int a0, a1, b4, tmp;

  initial begin
    valid = '0;
    last  = '0;
    for (int k = 0; k < N; k++) begin
      addr[k] = '0; we[k] = '0; wdata[k] = '0;
      cur_rdata[k] = '0; cur_err[k] = 1'b0;
    end
    rst_n = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fairness: both requesters hold two single-beat reads -> grants 0,1,0,1
    grant_log.delete();
    fork
      begin
        send(0, 24'h000200, 8'h00, '0, 1'b1, 64'h0001020304050607, 1'b0, a0);
        send(0, 24'h000210, 8'h00, '0, 1'b1, 64'h1011121314151617, 1'b0, a0);
        idle(0);
      end
      begin
        send(1, 24'h000308, 8'h00, '0, 1'b1, 64'h08090A0B0C0D0E0F, 1'b0, a1);
        send(1, 24'h000318, 8'h00, '0, 1'b1, 64'h18191A1B1C1D1E1F, 1'b0, a1);
        idle(1);
      end
    join
    check("fair_count", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("fair_order", 64'(grant_log[i]), 64'(i % 2));

    // Write then read back, including an unaligned read
    send(0, 24'h000100, 8'hFF, 64'h0011223344556677, 1'b1, 64'h0001020304050607, 1'b0, tmp);
    send(0, 24'h000100, 8'h00, '0, 1'b1, 64'h0011223344556677, 1'b0, tmp);
    send(0, 24'h000104, 8'h00, '0, 1'b1, 64'h4455667708090A0B, 1'b0, tmp);
    idle(0);

    // Partial strobe: only the lowest-address byte changes
    send(0, 24'h000000, 8'h80, 64'hAB00000000000000, 1'b1, 64'h0001020304050607, 1'b0, tmp);
    send(0, 24'h000000, 8'h00, '0, 1'b1, 64'hAB01020304050607, 1'b0, tmp);
    idle(0);

    // Out of range: accepted without touching the RAM, error response
    send(0, 24'h008000, 8'h00, '0, 1'b1, 64'd0, 1'b1, tmp);
    check("oor_read_ram_en", 64'(ram_en_o), 64'd0);
    send(0, 24'h008100, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'd0, 1'b1, tmp);
    check("oor_write_ram_en", 64'(ram_en_o), 64'd0);
    send(0, 24'h000100, 8'h00, '0, 1'b1, 64'h0011223344556677, 1'b0, tmp);
    idle(0);

    // Locked burst from requester 1 with a 2-cycle gap; requester 0 waits
    fork
      begin
        send(1, 24'h000400, 8'h00, '0, 1'b0, 64'h0001020304050607, 1'b0, a1);
        send(1, 24'h000408, 8'h00, '0, 1'b0, 64'h08090A0B0C0D0E0F, 1'b0, a1);
        idle(1);
        for (int g = 0; g < 2; g++) begin
          @(negedge clk);
          check("gap_ram_en", 64'(ram_en_o), 64'd0);
          check("gap_ready0", 64'(req_ready_o[0]), 64'd0);
        end
        send(1, 24'h000410, 8'h00, '0, 1'b0, 64'h1011121314151617, 1'b0, a1);
        send(1, 24'h000418, 8'h00, '0, 1'b1, 64'h18191A1B1C1D1E1F, 1'b0, b4);
        idle(1);
      end
      begin
        @(posedge clk);
        send(0, 24'h000500, 8'h00, '0, 1'b1, 64'h0001020304050607, 1'b0, a0);
        idle(0);
      end
    join
    check("lock_handoff", 64'(a0), 64'(b4 + 1));

    // Reset in the middle of a locked burst drops the in-flight response
    send(1, 24'h000600, 8'h00, '0, 1'b0, 64'h0001020304050607, 1'b0, tmp);
    send(1, 24'h000608, 8'h00, '0, 1'b0, 64'h08090A0B0C0D0E0F, 1'b0, tmp);
    #1;
    rst_n = 1'b0;
    sb.delete();
    addr[0] = 24'h000700; we[0] = '0; last[0] = 1'b1; valid[0] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_quiet("midrst");
    end
    valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    grant_log.delete();
    fork
      begin
        send(0, 24'h000700, 8'h00, '0, 1'b1, 64'h0001020304050607, 1'b0, a0);
        idle(0);
      end
      begin
        send(1, 24'h000708, 8'h00, '0, 1'b1, 64'h08090A0B0C0D0E0F, 1'b0, a1);
        idle(1);
      end
    join
    check("post_rst_count", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() >= 2) begin
      check("post_rst_first",  64'(grant_log[0]), 64'd0);
      check("post_rst_second", 64'(grant_log[1]), 64'd1);
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
